wavegen_sched: RTL and testbench

- Multi-channel PWM waveform scheduler: CH channels share one synchronous-read waveform ROM (1-cycle read latency, registered address) through fixed time-division slots.
- Each channel owns a phase accumulator and a PWM comparator against a shared period counter.
- Sits between the configuration registers (per-channel step) and the pins; drives the shared ROM address bus.

---
 rtl/wavegen_sched.sv | 133 +++++++++++++
 tb/tb_wavegen_sched.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/wavegen_sched.sv
// Multi-channel PWM scheduler: CH phase accumulators share one 1-cycle synchronous ROM through fixed slots.
// Optional common-phase realignment input is built when WAVEGEN_SCHED_PHASE_SYNC_EN is defined.
module wavegen_sched #(
    parameter int CH = 4,
    parameter int N  = 4,
    parameter int SN = 5,
    parameter int PW = 8
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             en,
    input  logic [CH*PW-1:0] step,
`ifdef WAVEGEN_SCHED_PHASE_SYNC_EN
    input  logic             sync,
`endif
    output logic [SN-1:0]    rom_addr,
    input  logic [N-1:0]     rom_data,
    output logic [CH-1:0]    pwm,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [N-1:0]    cnt;
    logic [PW-1:0]   phase    [CH];
    logic [N-1:0]    duty     [CH];
    logic [N-1:0]    next_dat [CH];
    logic            last;
    logic            boundary;
    logic            realign;

    assign busy     = (state != IDLE);
    assign last     = (cnt == {N{1'b1}});
    assign boundary = busy && last;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Dropping en at the final count of a period ends the run at that same wrap.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en) state_nxt = RUN;
            RUN:     if (!en) state_nxt = last ? IDLE : DRAIN;
            DRAIN:   begin
                if (en) begin
                    state_nxt = RUN;
                end else if (last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef WAVEGEN_SCHED_PHASE_SYNC_EN
    logic pend;

    // A pulse on the boundary cycle itself is kept for the following boundary.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            pend <= 1'b0;
        end else if (!busy || state_nxt == IDLE) begin
            pend <= 1'b0;
        end else if (boundary) begin
            pend <= sync;
        end else if (sync) begin
            pend <= 1'b1;
        end
    end

    assign realign = pend;
`else
    assign realign = 1'b0;
`endif

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            cnt <= '0;
        end else if (!busy) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Slot i issues channel i's address at cnt==i; the word arrives two counts later.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            rom_addr <= '0;
            for (int i = 0; i < CH; i++) begin
                phase[i]    <= '0;
                duty[i]     <= '0;
                next_dat[i] <= '0;
            end
        end else if (busy) begin
            for (int i = 0; i < CH; i++) begin
                if (int'(cnt) == i) begin
                    rom_addr <= phase[i][PW-1 -: SN];
                end
                if (int'(cnt) == i + 2) begin
                    next_dat[i] <= rom_data;
                end
                if (boundary) begin
                    duty[i]  <= next_dat[i];
                    phase[i] <= (realign ? '0 : phase[i]) + step[i*PW +: PW];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            pwm <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                pwm[i] <= busy && (cnt < duty[i]);
            end
        end
    end

endmodule

// File: tb/tb_wavegen_sched.sv
// Directed + randomized bench for wavegen_sched against a per-period reference model.
module tb_wavegen_sched;

    localparam int CH = 4;
    localparam int N  = 4;
    localparam int SN = 5;
    localparam int PW = 8;
    localparam int P  = 1 << N;

    logic             clk = 1'b0;
    logic             n_reset;
    logic             en;
    logic [CH*PW-1:0] step;
    logic [SN-1:0]    rom_addr;
    logic [N-1:0]     rom_data;
    logic [CH-1:0]    pwm;
    logic             busy;
`ifdef WAVEGEN_SCHED_PHASE_SYNC_EN
    logic             sync;
`endif

    logic             rom_force;
    logic [N-1:0]     rom_val;

    int checks = 0;
    int errors = 0;

    logic [PW-1:0] m_ph [CH];
    int            m_du [CH];

    wavegen_sched #(.CH(CH), .N(N), .SN(SN), .PW(PW)) dut (
        .clk      (clk),
        .n_reset  (n_reset),
        .en       (en),
        .step     (step),
`ifdef WAVEGEN_SCHED_PHASE_SYNC_EN
        .sync     (sync),
`endif
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .pwm      (pwm),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Bench ROM: word = low N address bits, optionally overridden by a constant.
    always @(posedge clk) rom_data <= rom_force ? rom_val : rom_addr[N-1:0];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_ph[i] = '0;
            m_du[i] = 0;
        end
    endtask

    // Called at the falling edge of the cnt==0 cycle of a running period.
    task automatic run_period(input logic [CH*PW-1:0] sa, input logic [CH*PW-1:0] sb,
                              input int drop_at, input int raise_at, input int sync_at);
        logic [SN-1:0] a [CH];
        int            d [CH];
        logic [CH-1:0] exp_pwm;
        for (int i = 0; i < CH; i++) begin
            a[i] = m_ph[i][PW-1 -: SN];
            d[i] = rom_force ? int'(rom_val) : int'(a[i]) % P;
        end
        step = sa;
        for (int c = 0; c < P; c++) begin
            if (c == 8) step = sb;
            if (c == drop_at) en = 1'b0;
            if (c == raise_at) en = 1'b1;
`ifdef WAVEGEN_SCHED_PHASE_SYNC_EN
            sync = (c == sync_at);
`endif
            for (int i = 0; i < CH; i++) exp_pwm[i] = (c >= 1) && (c - 1 < m_du[i]);
            check($sformatf("pwm_c%0d", c), 32'(pwm), 32'(exp_pwm));
            check($sformatf("busy_c%0d", c), 32'(busy), 32'd1);
            if (c >= 1 && c <= CH) check($sformatf("addr_slot%0d", c - 1), 32'(rom_addr), 32'(a[c-1]));
            @(negedge clk);
        end
`ifdef WAVEGEN_SCHED_PHASE_SYNC_EN
        sync = 1'b0;
`endif
        for (int i = 0; i < CH; i++) begin
            m_du[i] = d[i];
            m_ph[i] = (sync_at >= 0 ? 8'h00 : m_ph[i]) + sb[i*PW +: PW];
        end
        if (!en) begin
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_pwm", 32'(pwm), 32'd0);
        end
    endtask

    function automatic logic [CH*PW-1:0] rand_steps();
        logic [CH*PW-1:0] s;
        for (int i = 0; i < CH; i++) s[i*PW +: PW] = PW'($urandom);
        return s;
    endfunction

    initial begin
        logic [CH*PW-1:0] s8;
        logic [CH*PW-1:0] s2;
        logic [CH*PW-1:0] r;
        s8 = {CH{8'h08}};
        n_reset   = 1'b0;
        en        = 1'b1;
        step      = '0;
        rom_force = 1'b0;
        rom_val   = '0;
`ifdef WAVEGEN_SCHED_PHASE_SYNC_EN
        sync      = 1'b0;
`endif
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_pwm", 32'(pwm), 32'd0);
        check("rst_addr", 32'(rom_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        n_reset = 1'b1;
        #1 check("post_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);

        // Periods 0..3, with channel 2 wrapping from 0x10 to 0x08 at the end of period 2.
        run_period(s8, s8, -1, -1, -1);
        run_period(s8, s8, -1, -1, -1);
        s2 = s8;
        s2[2*PW +: PW] = 8'hF8;
        run_period(s2, s2, -1, -1, -1);
        run_period(s8, s8, -1, -1, -1);

        for (int k = 0; k < 4; k++) begin
            r = rand_steps();
            run_period(r, rand_steps(), -1, -1, -1);
        end

        rom_force = 1'b1;
        rom_val   = 4'hF;
        run_period(s8, s8, -1, -1, -1);
        rom_val   = 4'h0;
        run_period(s8, s8, -1, -1, -1);
        rom_force = 1'b0;
        run_period(s8, s8, -1, -1, -1);

        // Stop mid-period, idle a few cycles, restart with retained duties.
        run_period(rand_steps(), s8, 5, -1, -1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("idle_hold_busy", 32'(busy), 32'd0);
            check("idle_hold_pwm", 32'(pwm), 32'd0);
        end
        en = 1'b1;
        @(negedge clk);
        run_period(s8, rand_steps(), -1, -1, -1);

        run_period(s8, s8, 5, 10, -1);
        run_period(rand_steps(), rand_steps(), -1, -1, -1);

        // Asynchronous reset in the middle of a period.
        repeat (6) @(negedge clk);
        n_reset = 1'b0;
        #1;
        check("midrst_pwm", 32'(pwm), 32'd0);
        check("midrst_addr", 32'(rom_addr), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        model_reset();
        @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);
        run_period(s8, {8'h08, 8'h08, 8'h50, 8'h30}, -1, -1, -1);

`ifdef WAVEGEN_SCHED_PHASE_SYNC_EN
        run_period(s8, s8, -1, -1, 3);
        run_period(s8, s8, -1, -1, -1);
`else
        run_period(s8, s8, -1, -1, -1);
`endif
        run_period(rand_steps(), rand_steps(), -1, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
